// File: rtl/pio_in_irq.sv
// Parallel input port with per-bit synchronizer, optional debounce, edge capture and a
// maskable level interrupt. Register map: 0 data, 1 reserved, 2 irqmask, 3 edgecapture.
module pio_in_irq #(
  parameter int unsigned WIDTH     = 2,
  parameter int unsigned EDGE_TYPE = 0,
  parameter int unsigned DEBOUNCE  = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_stable;
  logic [WIDTH-1:0] r_irqmask;
  logic [WIDTH-1:0] r_edgecap;
  logic [31:0]      r_readdata;
  logic             r_irq;

  logic [WIDTH-1:0] w_stable_d;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clear;
  logic [WIDTH-1:0] w_irqmask_d;
  logic [WIDTH-1:0] w_edgecap_d;
  logic [31:0]      w_readdata_d;
  logic             w_wr;
  logic             w_unused_wdata;

  assign w_wr           = chipselect & ~write_n;
  assign w_unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

  generate
    if (DEBOUNCE == 0) begin : g_no_debounce
      assign w_stable_d = r_sync2;
    end else begin : g_debounce
      localparam logic [15:0] CntMax = 16'(DEBOUNCE - 1);
      for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        logic [15:0] r_cnt;
        logic [15:0] w_cnt_d;
        logic        w_stable_bit;

        // A change is taken only on the DEBOUNCE-th consecutive differing cycle.
        always_comb begin
          w_cnt_d      = r_cnt;
          w_stable_bit = r_stable[i];
          if (r_sync2[i] == r_stable[i]) begin
            w_cnt_d = '0;
          end else if (r_cnt == CntMax) begin
            w_stable_bit = r_sync2[i];
            w_cnt_d      = '0;
          end else begin
            w_cnt_d = r_cnt + 16'd1;
          end
        end

        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= w_cnt_d;
          end
        end

        assign w_stable_d[i] = w_stable_bit;
      end
    end
  endgenerate

  always_comb begin
    if (EDGE_TYPE == 0) begin
      w_edge = w_stable_d & ~r_stable;
    end else if (EDGE_TYPE == 1) begin
      w_edge = ~w_stable_d & r_stable;
    end else begin
      w_edge = w_stable_d ^ r_stable;
    end
  end

  // A new edge overrides a clear of the same bit in the same cycle.
  always_comb begin
    w_clear     = '0;
    w_irqmask_d = r_irqmask;
    if (w_wr && (address == 2'd3)) begin
      w_clear = writedata[WIDTH-1:0];
    end
    if (w_wr && (address == 2'd2)) begin
      w_irqmask_d = writedata[WIDTH-1:0];
    end
    w_edgecap_d = (r_edgecap & ~w_clear) | w_edge;
  end

  always_comb begin
    w_readdata_d = '0;
    unique case (address)
      2'd0: w_readdata_d[WIDTH-1:0] = r_stable;
      2'd1: w_readdata_d            = '0;
      2'd2: w_readdata_d[WIDTH-1:0] = r_irqmask;
      2'd3: w_readdata_d[WIDTH-1:0] = r_edgecap;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable   <= '0;
      r_irqmask  <= '0;
      r_edgecap  <= '0;
      r_readdata <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_stable   <= w_stable_d;
      r_irqmask  <= w_irqmask_d;
      r_edgecap  <= w_edgecap_d;
      r_readdata <= w_readdata_d;
      r_irq      <= |(r_edgecap & r_irqmask);
    end
  end

  assign readdata = r_readdata;
  assign irq      = r_irq;

endmodule
